// File: rtl/key_cam_pkg.sv
// Shared constants and entry layout for reverse_key_cam.
// The default_key port exists only under REVERSE_KEY_CAM_DEFAULT_EN.
package key_cam_pkg;

  localparam int NR_KEY_DEF   = 4;
  localparam int KEY_LEN_DEF  = 2;
  localparam int DATA_LEN_DEF = 8;

  typedef struct packed {
    logic                    valid;
    logic [KEY_LEN_DEF-1:0]  key;
    logic [DATA_LEN_DEF-1:0] data;
  } key_cam_entry_t;

endpackage

// File: rtl/key_cam_match.sv
// Compare a query against all valid entries and
// return the lowest matching index.
module key_cam_match #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]        vld_i,
  input  logic [N-1:0][W-1:0] val_i,
  input  logic [W-1:0]        q_i,
  output logic                hit_o,
  output logic [IW-1:0]       idx_o
);

  // Scan downward so the lowest index is written last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vld_i[i] && (val_i[i] == q_i)) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/reverse_key_cam.sv
// Small CAM mapping data back to key, 1-cycle lookup.
// Define REVERSE_KEY_CAM_DEFAULT_EN to add the default_key miss port.
module reverse_key_cam
  import key_cam_pkg::*;
#(
  parameter int NR_KEY   = NR_KEY_DEF,
  parameter int KEY_LEN  = KEY_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [DATA_LEN-1:0] lk_data,
`ifdef REVERSE_KEY_CAM_DEFAULT_EN
  input  logic [KEY_LEN-1:0]  default_key,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [KEY_LEN-1:0]  rsp_key,
  output logic                rsp_hit
);

  localparam int IW = $clog2(NR_KEY);

  logic [NR_KEY-1:0]               vld_q;
  logic [NR_KEY-1:0][KEY_LEN-1:0]  key_q;
  logic [NR_KEY-1:0][DATA_LEN-1:0] data_q;
  logic [IW-1:0]                   ptr_q;

  logic               rsp_valid_q;
  logic               rsp_hit_q;
  logic [KEY_LEN-1:0] rsp_key_q;

  logic               lk_hit;
  logic [IW-1:0]      lk_idx;
  logic               wr_hit;
  logic [IW-1:0]      wr_idx;
  logic               free_any;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      tgt_idx;
  logic               replace;
  logic               wr_fire;
  logic               lk_fire;
  logic [KEY_LEN-1:0] miss_key;

  assign wr_ready  = !clr;
  assign lk_ready  = !rsp_valid_q || rsp_ready;
  assign wr_fire   = wr_valid && !clr;
  assign lk_fire   = lk_valid && lk_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_key   = rsp_key_q;
  assign rsp_hit   = rsp_hit_q;

`ifdef REVERSE_KEY_CAM_DEFAULT_EN
  assign miss_key = default_key;
`else
  assign miss_key = '0;
`endif

  key_cam_match #(
    .N  (NR_KEY),
    .W  (DATA_LEN),
    .IW (IW)
  ) u_dmatch (
    .vld_i (vld_q),
    .val_i (data_q),
    .q_i   (lk_data),
    .hit_o (lk_hit),
    .idx_o (lk_idx)
  );

  key_cam_match #(
    .N  (NR_KEY),
    .W  (KEY_LEN),
    .IW (IW)
  ) u_kmatch (
    .vld_i (vld_q),
    .val_i (key_q),
    .q_i   (wr_key),
    .hit_o (wr_hit),
    .idx_o (wr_idx)
  );

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Overwrite in place, else fill a hole, else evict at ptr.
  always_comb begin
    if (wr_hit)
      tgt_idx = wr_idx;
    else if (free_any)
      tgt_idx = free_idx;
    else
      tgt_idx = ptr_q;
  end

  assign replace = wr_fire && !wr_hit && !free_any;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      ptr_q <= '0;
    end else if (clr) begin
      vld_q <= '0;
      ptr_q <= '0;
    end else if (wr_fire) begin
      vld_q[tgt_idx] <= 1'b1;
      if (replace)
        ptr_q <= ptr_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) begin
      key_q[tgt_idx]  <= wr_key;
      data_q[tgt_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_key_q   <= '0;
    end else if (lk_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_hit_q   <= lk_hit;
      rsp_key_q   <= lk_hit ? key_q[lk_idx] : miss_key;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reverse_key_cam.sv
// Randomized bench for reverse_key_cam against a behavioural model.
// Works with or without REVERSE_KEY_CAM_DEFAULT_EN.
module tb_reverse_key_cam;

  localparam int NK = 4;
  localparam int KL = 3;
  localparam int DL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [KL-1:0] wr_key;
  logic [DL-1:0] wr_data;
  logic          clr;
  logic          lk_valid;
  logic          lk_ready;
  logic [DL-1:0] lk_data;
  logic [KL-1:0] default_key;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [KL-1:0] rsp_key;
  logic          rsp_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reverse_key_cam #(
    .NR_KEY   (NK),
    .KEY_LEN  (KL),
    .DATA_LEN (DL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_key      (wr_key),
    .wr_data     (wr_data),
    .clr         (clr),
    .lk_valid    (lk_valid),
    .lk_ready    (lk_ready),
    .lk_data     (lk_data),
`ifdef REVERSE_KEY_CAM_DEFAULT_EN
    .default_key (default_key),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_key     (rsp_key),
    .rsp_hit     (rsp_hit)
  );

  // Behavioural model: list of entries plus a rotating victim slot.
  bit            mv[NK];
  logic [KL-1:0] mk[NK];
  logic [DL-1:0] md[NK];
  int            mptr = 0;
  bit            ev = 0;
  logic [KL-1:0] ek = '0;
  bit            eh = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [KL-1:0] miss_val();
`ifdef REVERSE_KEY_CAM_DEFAULT_EN
    return default_key;
`else
    return '0;
`endif
  endfunction

  task automatic model_write(logic [KL-1:0] k, logic [DL-1:0] d);
    int slot = -1;
    for (int i = 0; i < NK; i++)
      if (slot < 0 && mv[i] && mk[i] == k) slot = i;
    for (int i = 0; i < NK; i++)
      if (slot < 0 && !mv[i]) slot = i;
    if (slot < 0) begin
      slot = mptr;
      mptr = (mptr + 1) % NK;
    end
    mv[slot] = 1;
    mk[slot] = k;
    md[slot] = d;
  endtask

  task automatic step();
    bit            lacc;
    bit            wacc;
    bit            h;
    logic [KL-1:0] k;
    bit            do_clr;
    bit            rdy;
    bit            rst;
    logic [KL-1:0] wk;
    logic [DL-1:0] wd;
    #1;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, !clr});
    chk("lk_ready", {31'd0, lk_ready}, {31'd0, (!ev || rsp_ready)});
    lacc = lk_valid && (!ev || rsp_ready);
    wacc = wr_valid && !clr;
    do_clr = clr;
    rdy = rsp_ready;
    rst = !rst_n;
    wk = wr_key;
    wd = wr_data;
    h = 0;
    k = '0;
    for (int i = 0; i < NK; i++)
      if (!h && mv[i] && md[i] == lk_data) begin
        h = 1;
        k = mk[i];
      end
    if (!h) k = miss_val();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NK; i++) mv[i] = 0;
      mptr = 0;
      ev = 0;
      ek = '0;
      eh = 0;
    end else begin
      if (lacc) begin
        ev = 1;
        ek = k;
        eh = h;
      end else if (rdy) begin
        ev = 0;
      end
      if (do_clr) begin
        for (int i = 0; i < NK; i++) mv[i] = 0;
        mptr = 0;
      end else if (wacc) begin
        model_write(wk, wd);
      end
    end
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
    if (ev || rst) begin
      chk("rsp_key", {29'd0, rsp_key}, {29'd0, ek});
      chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, eh});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wr_valid = 0;
    lk_valid = 0;
    clr = 0;
  endtask

  task automatic wr(logic [KL-1:0] k, logic [DL-1:0] d);
    idle();
    wr_valid = 1;
    wr_key = k;
    wr_data = d;
    step();
    idle();
  endtask

  task automatic lk(logic [DL-1:0] d);
    idle();
    lk_valid = 1;
    lk_data = d;
    step();
    idle();
  endtask

  logic [DL-1:0] dtab[6] = '{8'h11, 8'h22, 8'h40, 8'h77, 8'h99, 8'h55};

  initial begin
    rst_n = 0;
    rsp_ready = 1;
    wr_key = '0;
    wr_data = '0;
    lk_data = '0;
    default_key = 3'd3;
    idle();
    @(negedge clk);
    step();
    step();
    rst_n = 1;

    // Basic hit, then empty-table miss.
    wr(3'd1, 8'h11);
    wr(3'd2, 8'h22);
    lk(8'h22);
    chk("basic_key", {29'd0, rsp_key}, 32'd2);
    chk("basic_hit", {31'd0, rsp_hit}, 32'd1);
    clr = 1;
    step();
    idle();
    lk(8'h55);
    chk("empty_hit", {31'd0, rsp_hit}, 32'd0);
    step();

    // Overwrite in place, then eviction order 0,1.
    for (int i = 0; i < NK; i++) wr(KL'(i), 8'hA0 + 8'(i));
    wr(3'd1, 8'h99);
    lk(8'h99);
    chk("ovw_key", {29'd0, rsp_key}, 32'd1);
    wr(3'd4, 8'h44);
    lk(8'hA0);
    chk("evict0_hit", {31'd0, rsp_hit}, 32'd0);
    wr(3'd5, 8'h45);
    lk(8'h99);
    chk("evict1_hit", {31'd0, rsp_hit}, 32'd0);
    lk(8'h45);
    chk("evict1_key", {29'd0, rsp_key}, 32'd5);

    // Duplicate data: lowest index wins.
    clr = 1;
    step();
    idle();
    wr(3'd0, 8'h40);
    wr(3'd3, 8'h40);
    lk(8'h40);
    chk("prio_key", {29'd0, rsp_key}, 32'd0);

    // Backpressure, then back-to-back lookups.
    rsp_ready = 0;
    lk(8'h40);
    lk_valid = 1;
    lk_data = 8'h11;
    repeat (3) step();
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      lk_data = (i % 2 == 0) ? 8'h40 : 8'h22;
      step();
    end
    idle();
    step();

    // Same-cycle write and lookup sees old contents; clr hides data.
    wr_valid = 1;
    wr_key = 3'd2;
    wr_data = 8'h77;
    lk_valid = 1;
    lk_data = 8'h77;
    step();
    idle();
    chk("wr_lk_hit", {31'd0, rsp_hit}, 32'd0);
    lk(8'h77);
    chk("rep_key", {29'd0, rsp_key}, 32'd2);
    clr = 1;
    lk_valid = 1;
    lk_data = 8'h77;
    step();
    idle();
    chk("clr_lk_hit", {31'd0, rsp_hit}, 32'd1);
    lk(8'h77);
    chk("post_clr_hit", {31'd0, rsp_hit}, 32'd0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_key = KL'($urandom_range(0, 7));
      wr_data = dtab[$urandom_range(0, 5)];
      lk_valid = ($urandom_range(0, 1) == 0);
      lk_data = dtab[$urandom_range(0, 5)];
      clr = ($urandom_range(0, 19) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      default_key = KL'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
